sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch requester and the data requester.
- Sits between the mips core's inst/data request ports and a unified memory macro.
- Data has priority, with a starvation guard so instruction fetch still makes progress.
- Sequences each access over a fixed read latency and returns a one-cycle completion pulse that the core uses as its stall release.

Parameters:
- LAT, 1, SRAM read latency in cycles (legal 1..4); every access, read or write, takes LAT cycles after issue.
- MAX_DATA_STREAK, 3, consecutive contested data grants allowed before inst is forced to win (legal 1..15).

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- inst_req  input  1  fetch request; level, held until inst_ok
- inst_addr  input  32  fetch byte address; stable while inst_req high
- inst_rdata  output  32  fetch data, valid only when inst_ok=1
- inst_ok  output  1  one-cycle completion pulse for fetch
- data_req  input  1  data request; level, held until data_ok
- data_wen  input  4  byte write enables; 0000 means read
- data_addr  input  32  data byte address
- data_wdata  input  32  store data
- data_rdata  output  32  load data, valid only when data_ok=1
- data_ok  output  1  one-cycle completion pulse for data
- mem_en  output  1  SRAM enable, high only in the issue cycle
- mem_wen  output  4  SRAM byte write enables
- mem_addr  output  32  SRAM address
- mem_wdata  output  32  SRAM write data
- mem_rdata  input  32  SRAM read data, valid LAT cycles after the mem_en cycle

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE; cnt, owner and streak clear to 0.
  - mem_en=0, mem_wen=0000, inst_ok=0, data_ok=0.
  - All outputs are forced to these values immediately, regardless of requests.
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding; cnt counts 1..LAT; owner is a 1-bit register, 0=inst, 1=data.
- IDLE, issue (combinational):
  - If any request is present, choose a winner, drive mem_en=1 with the winner's addr, wen and wdata, and go to WAIT with cnt=1.
  - An inst winner drives mem_wen=0000 and mem_wdata=0.
- Arbitration:
  - Data wins unless streak==MAX_DATA_STREAK and inst_req=1, in which case inst wins.
  - A lone request always wins.
- Streak rules:
  - Data granted while inst_req=1: streak+1, saturating.
  - Inst granted: streak cleared.
  - Inst_req low at a grant: streak cleared.
- WAIT:
  - cnt<LAT: cnt+1, mem_en=0.
  - cnt==LAT: assert the owner's ok for exactly that cycle, pass mem_rdata straight through to the owner's rdata, return to IDLE.
- Latency:
  - ok arrives LAT cycles after the issue cycle.
  - The earliest next issue is the cycle after ok, so sustained throughput is one access per LAT+1 cycles.
- rdata outputs are 0 when their ok is low. Writes also pulse data_ok, and data_rdata is then don't-care (drive mem_rdata).
- Requester protocol:
  - A requester may keep req high after ok to request a new access, with new address/data presented from the cycle after ok.
  - Dropping req while its access is outstanding is illegal. The arbiter still completes the access and pulses ok.
- Changes to a non-owner's inputs during WAIT have no effect on the outstanding access.
- mem_addr is passed unmodified; no alignment checking is done here (the core raises adel/ades).
- Reset asserted during WAIT aborts the access: no ok pulse, and the requester must reissue after reset.
- inst_ok and data_ok are never high in the same cycle.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt (32 bits): increments every cycle in which the arbiter is in IDLE, both inst_req and data_req are high, and the arbiter issues.
  - Adds output stall_cnt (32 bits): increments every cycle in which the arbiter is in WAIT and the non-owner's req is high.
  - Both wrap at 2^32, reset to 0, and are readable at any time.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- LAT=1, inst_req alone, inst_addr=0xBFC00000, mem_rdata=0x3C1D8001 at t+1 -> mem_en=1 at t, inst_ok=1 at t+1 with inst_rdata=0x3C1D8001, idle at t+2.
- LAT=1, data_req with data_wen=1111, data_addr=0x80001000, data_wdata=0xDEADBEEF -> mem_wen=1111, mem_wdata=0xDEADBEEF at issue, data_ok one cycle later, inst_ok never asserted.
- LAT=1, MAX_DATA_STREAK=3, inst_req and data_req held high continuously -> grant order D,D,D,I,D,D,D,I; each ok is 2 cycles apart; streak returns to 0 after each I.
- LAT=3, single read -> mem_en high 1 cycle, ok exactly 3 cycles after issue, mem_en=0 during cnt=1,2.
- resetn pulled low in WAIT at cnt=1 with LAT=2 -> mem_en, inst_ok and data_ok are 0 immediately; no ok ever pulses for the aborted access; the first request after release is issued normally.
- With SRAM_ARB_PERF_EN, LAT=1, both requests high for 4 accesses (8 cycles) -> conflict_cnt=4, stall_cnt=4.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the core's inst/data ports, the arbiter and the SRAM macro.
// slave = arbiter side, master = core + SRAM side.
interface sram_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
    input  inst_rdata, inst_ok, data_rdata, data_ok, mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, mem_rdata,
    output inst_rdata, inst_ok, data_rdata, data_ok, mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data; data has priority with a
// streak guard for fetch. Optional perf counters (conflict_cnt, stall_cnt): define SRAM_ARB_PERF_EN.
module sram_port_arbiter #(
  parameter int LAT             = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic               clk,
  input  logic               resetn,
  sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]        conflict_cnt,
  output logic [31:0]        stall_cnt
`endif
);
  // state  | meaning
  // S_IDLE | no access outstanding; issues in the same cycle a request is seen
  // S_WAIT | access outstanding; cnt counts 1..LAT, owner's ok pulses at cnt==LAT
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int              CW         = $clog2(LAT + 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(LAT);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [3:0]      STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic [3:0]    streak;
  logic          inst_ok_q;
  logic          data_ok_q;
  logic          any_req;
  logic          inst_win;
  logic          issue;
  logic          data_issue;

  assign any_req    = bus.inst_req | bus.data_req;
  assign inst_win   = bus.inst_req & (~bus.data_req | (streak == STREAK_MAX));
  // resetn gates issue so a held request cannot reach the SRAM while reset is low
  assign issue      = resetn & (state == S_IDLE) & any_req;
  assign data_issue = issue & ~inst_win;

  assign bus.mem_en     = issue;
  assign bus.mem_wen    = data_issue ? bus.data_wen : 4'b0000;
  assign bus.mem_addr   = inst_win ? bus.inst_addr : bus.data_addr;
  assign bus.mem_wdata  = data_issue ? bus.data_wdata : 32'h0;
  assign bus.inst_ok    = inst_ok_q;
  assign bus.data_ok    = data_ok_q;
  assign bus.inst_rdata = inst_ok_q ? bus.mem_rdata : 32'h0;
  assign bus.data_rdata = data_ok_q ? bus.mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      streak    <= '0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state <= S_WAIT;
            cnt   <= CNT_ONE;
            owner <= ~inst_win;
            if (inst_win || !bus.inst_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 4'd1;
            end
            if (CNT_LAST == CNT_ONE) begin
              inst_ok_q <= inst_win;
              data_ok_q <= ~inst_win;
            end
          end
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
            // ok is registered, so it is raised on the edge that enters cnt==LAT
            if (cnt + CNT_ONE == CNT_LAST) begin
              inst_ok_q <= ~owner;
              data_ok_q <= owner;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if (issue && bus.inst_req && bus.data_req) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if ((state == S_WAIT) && (owner ? bus.inst_req : bus.data_req)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif
endmodule
